// File: rtl/frame_mem_writer.sv
// Packs four consecutive active pixels into one memory word and writes each frame
// to addresses 0..ADDR_DEPTH-1. It also flags line-length and frame-overflow errors.
module frame_mem_writer #(
   parameter int HRES       = 320,
   parameter int VRES       = 240,
   parameter int DATA_WIDTH = 24,
   parameter int MEM_WIDTH  = DATA_WIDTH * 4,
   parameter int ADDR_DEPTH = HRES * VRES / 4,
   parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  rst,
   input  logic                  i_vsync,
   input  logic                  i_hsync,
   input  logic                  i_de,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_fmem_csn,
   output logic                  o_fmem_wen,
   output logic [ADDR_WIDTH-1:0] o_fmem_addr,
   output logic [MEM_WIDTH-1:0]  o_fmem_din,
   output logic                  o_frame_done,
   output logic                  o_line_err,
   output logic                  o_ovf_err
);

   localparam int RUN_WIDTH  = $clog2(HRES + 1) + 1;
   localparam int PACK_WIDTH = MEM_WIDTH - DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t                r_state;
   logic                  r_vsync_d;
   logic                  r_hsync_d;
   logic                  r_de_d;
   logic [1:0]            r_lane;
   logic [PACK_WIDTH-1:0] r_pack;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [RUN_WIDTH-1:0]  r_run;
   logic                  r_done_pend;

   logic w_vs_rise;
   logic w_hs_rise;
   logic w_de_fall;

   assign w_vs_rise = i_vsync & ~r_vsync_d;
   assign w_hs_rise = i_hsync & ~r_hsync_d;
   assign w_de_fall = r_de_d & ~i_de;

   always_ff @(posedge i_clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_vsync_d    <= 1'b0;
         r_hsync_d    <= 1'b0;
         r_de_d       <= 1'b0;
         r_lane       <= 2'd0;
         r_pack       <= '0;
         r_addr       <= '0;
         r_run        <= '0;
         r_done_pend  <= 1'b0;
         o_fmem_csn   <= 1'b1;
         o_fmem_wen   <= 1'b1;
         o_fmem_addr  <= '0;
         o_fmem_din   <= '0;
         o_frame_done <= 1'b0;
         o_line_err   <= 1'b0;
         o_ovf_err    <= 1'b0;
      end else begin
         r_vsync_d    <= i_vsync;
         r_hsync_d    <= i_hsync;
         r_de_d       <= i_de;
         o_fmem_csn   <= 1'b1;
         o_fmem_wen   <= 1'b1;
         r_done_pend  <= 1'b0;
         o_frame_done <= r_done_pend;

         // Run length saturates so an over-long line still reads as wrong.
         if (i_de && (r_run != {RUN_WIDTH{1'b1}}))
            r_run <= r_run + RUN_WIDTH'(1);
         if (w_de_fall) begin
            r_run <= '0;
            if (r_run != RUN_WIDTH'(HRES))
               o_line_err <= 1'b1;
         end
         if (w_hs_rise && i_de)
            o_line_err <= 1'b1;

         if (w_vs_rise) begin
            // A new frame wins over any pixel or error arriving in the same cycle.
            r_state    <= S_ACTIVE;
            r_addr     <= '0;
            r_lane     <= 2'd0;
            o_line_err <= 1'b0;
            o_ovf_err  <= 1'b0;
         end else begin
            case (r_state)
               S_ACTIVE: begin
                  if (i_de) begin
                     if (r_lane == 2'd3) begin
                        o_fmem_csn  <= 1'b0;
                        o_fmem_wen  <= 1'b0;
                        o_fmem_addr <= r_addr;
                        o_fmem_din  <= {i_data, r_pack};
                        r_lane      <= 2'd0;
                        if (r_addr == ADDR_WIDTH'(ADDR_DEPTH - 1)) begin
                           r_state     <= S_DONE;
                           r_done_pend <= 1'b1;
                        end else begin
                           r_addr <= r_addr + ADDR_WIDTH'(1);
                        end
                     end else begin
                        for (int k = 0; k < 3; k++) begin
                           if (r_lane == 2'(k))
                              r_pack[k*DATA_WIDTH +: DATA_WIDTH] <= i_data;
                        end
                        r_lane <= r_lane + 2'd1;
                     end
                  end
               end
               S_DONE: begin
                  if (i_de)
                     o_ovf_err <= 1'b1;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_mem_writer.sv
// Directed bench for frame_mem_writer on a small 8x2 frame. A scoreboard queue
// predicts each memory write, and a monitor checks every strobe as it happens.
module tb_frame_mem_writer;

   localparam int HRES  = 8;
   localparam int VRES  = 2;
   localparam int DW    = 24;
   localparam int MW    = DW * 4;
   localparam int DEPTH = HRES * VRES / 4;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst;
   logic          vsync, hsync, de;
   logic [DW-1:0] data;
   logic          csn, wen, frame_done, line_err, ovf_err;
   logic [AW-1:0] addr;
   logic [MW-1:0] din;

   frame_mem_writer #(
      .HRES(HRES), .VRES(VRES), .DATA_WIDTH(DW)
   ) dut (
      .i_clk(clk), .rst(rst), .i_vsync(vsync), .i_hsync(hsync), .i_de(de),
      .i_data(data), .o_fmem_csn(csn), .o_fmem_wen(wen), .o_fmem_addr(addr),
      .o_fmem_din(din), .o_frame_done(frame_done), .o_line_err(line_err),
      .o_ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int last_final_cyc = -10;
   logic [MW-1:0] last_din;

   logic [AW+MW-1:0] exp_q[$];
   logic [MW-1:0]    m_pack;
   int               m_lane;
   int               m_addr;
   bit               m_active;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // The monitor samples on the falling edge, away from the DUT's update edge.
   always @(negedge clk) begin
      if (csn === 1'b0) begin
         logic [AW+MW-1:0] e;
         wr_cnt++;
         last_din = din;
         check("wen_with_csn", 128'(wen), 128'(0));
         check("write_expected", 128'(exp_q.size() != 0), 128'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 128'(addr), 128'(e[AW+MW-1:MW]));
            check("wr_din", 128'(din), 128'(e[MW-1:0]));
         end
         if (addr == AW'(DEPTH - 1)) last_final_cyc = cyc;
      end
      if (frame_done === 1'b1) begin
         done_cnt++;
         check("done_timing", 128'(cyc), 128'(last_final_cyc + 1));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      de = 1'b0;
      repeat (n) tick();
   endtask

   task automatic vsync_pulse();
      vsync    = 1'b1;
      de       = 1'b0;
      m_active = 1'b1;
      m_lane   = 0;
      m_addr   = 0;
      tick();
      vsync = 1'b0;
      idle(2);
   endtask

   task automatic send_pixel(input logic [DW-1:0] d);
      de   = 1'b1;
      data = d;
      if (m_active) begin
         m_pack = {d, m_pack[MW-1:DW]};
         m_lane++;
         if (m_lane == 4) begin
            exp_q.push_back({AW'(m_addr), m_pack});
            m_lane = 0;
            m_addr++;
            if (m_addr == DEPTH) m_active = 1'b0;
         end
      end
      tick();
   endtask

   task automatic send_line(input int n, input int base);
      for (int i = 0; i < n; i++) send_pixel(DW'(base + i));
      idle(3);
   endtask

   initial begin
      int wr0, dn0;
      rst = 1'b1; vsync = 1'b0; hsync = 1'b0; de = 1'b0; data = '0;
      m_active = 1'b0; m_lane = 0; m_addr = 0; m_pack = '0;

      // Reset held for three cycles while DE toggles.
      for (int i = 0; i < 3; i++) begin
         de   = ~de;
         data = DW'(i + 100);
         tick();
         check("rst_csn", 128'(csn), 128'(1));
         check("rst_wen", 128'(wen), 128'(1));
         check("rst_addr", 128'(addr), 128'(0));
      end
      check("rst_din", 128'(din), 128'(0));
      check("rst_done", 128'(frame_done), 128'(0));
      check("rst_errs", 128'({line_err, ovf_err}), 128'(0));
      rst = 1'b0;
      idle(3);
      check("rst_no_writes", 128'(wr_cnt), 128'(0));

      // A single frame of pixels 1..16.
      vsync_pulse();
      send_line(HRES, 1);
      send_line(HRES, 9);
      idle(3);
      check("f1_writes", 128'(wr_cnt), 128'(4));
      check("f1_done", 128'(done_cnt), 128'(1));
      check("f1_last_din", 128'(last_din), 128'(96'h000010_00000F_00000E_00000D));
      check("f1_errs", 128'({line_err, ovf_err}), 128'(0));

      // Three back-to-back frames with random pixels.
      for (int f = 0; f < 3; f++) begin
         vsync_pulse();
         for (int l = 0; l < VRES; l++) begin
            for (int p = 0; p < HRES; p++) send_pixel(DW'($urandom));
            idle(3);
         end
      end
      idle(3);
      check("f3_writes", 128'(wr_cnt), 128'(16));
      check("f3_done", 128'(done_cnt), 128'(4));
      check("f3_errs", 128'({line_err, ovf_err}), 128'(0));

      // A short line: packing continues across lines, and the error is sticky until vsync.
      vsync_pulse();
      send_line(7, 32'h200);
      check("short_line_err", 128'(line_err), 128'(1));
      send_line(HRES, 32'h300);
      check("short_line_sticky", 128'(line_err), 128'(1));
      check("short_writes", 128'(wr_cnt), 128'(19));
      vsync_pulse();
      check("short_cleared", 128'(line_err), 128'(0));

      // Extra pixels after a complete frame are dropped and flag overflow.
      send_line(HRES, 32'h400);
      send_line(HRES, 32'h500);
      check("ovf_pre", 128'(ovf_err), 128'(0));
      send_line(4, 32'h600);
      idle(2);
      check("ovf_err", 128'(ovf_err), 128'(1));
      check("ovf_writes", 128'(wr_cnt), 128'(23));
      check("ovf_done", 128'(done_cnt), 128'(5));

      // Reset between the 2nd and 3rd pixels of a group: that group is abandoned.
      vsync_pulse();
      send_pixel(24'hAAAA01);
      send_pixel(24'hAAAA02);
      rst = 1'b1; de = 1'b0; m_active = 1'b0; m_lane = 0;
      tick();
      rst = 1'b0;
      check("rst_mid_csn", 128'(csn), 128'(1));
      check("rst_mid_errs", 128'({line_err, ovf_err}), 128'(0));
      wr0 = wr_cnt;
      send_line(6, 32'hBB00);
      check("rst_mid_idle_drop", 128'(wr_cnt), 128'(wr0));
      dn0 = done_cnt;
      vsync_pulse();
      send_line(HRES, 32'hC00);
      send_line(HRES, 32'hD00);
      idle(3);
      check("rst_mid_writes", 128'(wr_cnt), 128'(wr0 + 4));
      check("rst_mid_done", 128'(done_cnt), 128'(dn0 + 1));
      check("queue_drained", 128'(exp_q.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
